_or_serial: RTL and testbench
=============================

Name: _or_serial

Overview:
- Bit-serial counterpart of the parallel ripple OR reducer.
- Accepts one input bit per handshake and ORs successive bits into an accumulator.
- After exactly INPUT_WIDTH accepted bits, presents the reduced result on a valid/ready output.
- Used where operand bits arrive serially, e.g. from shift registers or serial links, instead of as a parallel word.

Parameters:
- INPUT_WIDTH, 8, number of serial bits reduced per result word; legal range 1..255.
- COUNT_WIDTH, 8, bit-counter width; must satisfy 2^COUNT_WIDTH > INPUT_WIDTH.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- DigitSupply  input  2  logic levels: [0] = logic 0 level, [1] = logic 1 level. All constant drives (reset values, clears) are taken from these bits.
- inputBit  input  1  serial operand bit.
- inputValid  input  1  inputBit is valid this cycle.
- inputReady  output  1  block can accept a bit this cycle.
- clearIn  input  1  synchronous abort of the current word.
- outputData  output  1  OR of the INPUT_WIDTH accepted bits.
- outputValid  output  1  outputData is valid.
- outputReady  input  1  consumer accepts the result.
- bitCount  output  COUNT_WIDTH  number of bits accepted in the current word.

Behaviour:
- Clocking and reset:
  - One clock (Clock). Reset is synchronous and active-high, sampled on the rising edge.
  - Reset has priority over every other input.
- Reset values:
  - state = ACCUM, accumulator = DigitSupply[0], bitCount = 0.
  - outputData = DigitSupply[0], outputValid = 0, inputReady = 1 (from the cycle after reset).
- State ACCUM:
  - inputReady = 1, outputValid = 0.
  - Input transfer occurs when inputValid && inputReady.
  - On a transfer: acc <= acc | inputBit, bitCount <= bitCount + 1.
  - If the transfer is the INPUT_WIDTH-th bit (bitCount == INPUT_WIDTH-1 before the edge):
    - outputData <= acc | inputBit, outputValid <= 1, bitCount <= INPUT_WIDTH, state <= HOLD.
  - Latency: result is valid on the cycle after the last bit transfer.
- State HOLD:
  - inputReady = 0. outputData and outputValid are held stable until accepted.
  - Output transfer occurs when outputValid && outputReady.
  - On an output transfer: acc <= DigitSupply[0], bitCount <= 0, outputValid <= 0, state <= ACCUM.
  - The next bit can be accepted on the cycle after the output transfer (one bubble per word).
  - outputData keeps its last value after the transfer; it is only meaningful while outputValid = 1.
- clearIn:
  - In ACCUM: discards partial accumulation (acc = 0, bitCount = 0). An inputBit offered in the same cycle is dropped.
  - In HOLD: discards the pending result (outputValid = 0, state = ACCUM).
  - Priority order: Reset > clearIn > transfers.
- Boundaries:
  - INPUT_WIDTH = 1: every accepted bit produces a result directly (ACCUM -> HOLD on each transfer).
  - inputValid high in HOLD is ignored; no bit is consumed.
  - outputReady high in ACCUM has no effect.
  - Accumulator saturates at 1; once set it stays 1 until the word completes or is cleared.
  - bitCount never exceeds INPUT_WIDTH and never wraps.
  - Reset mid-word discards the partial word; no output is produced for it.

Optional Feature:
- Macro: OR_SERIAL_FIRST_INDEX_EN.
- When defined, adds:
  - output firstIndex [COUNT_WIDTH-1:0]: index (0-based, arrival order) of the first accepted 1 bit in the word. Captured on that bit's transfer.
  - output firstIndexValid (1 bit): 1 iff any 1 bit was seen in the word.
- Both outputs are held, and valid, with outputValid. Both are cleared on Reset, clearIn, and on output transfer.
- When not defined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then INPUT_WIDTH=8, bits 0,0,0,0,0,0,0,0 with continuous inputValid -> outputValid=1 one cycle after the 8th transfer, outputData=0, bitCount=8.
- Bits 0,0,1,0,0,0,0,0, outputReady held low for 5 cycles -> outputData=1 stable, inputReady=0 throughout HOLD; with the macro, firstIndex=2 and firstIndexValid=1.
- Bits offered with inputValid toggling every other cycle -> only valid cycles are counted; result appears after the 8th valid transfer.
- 4 bits accepted, then clearIn=1 while inputValid=1 -> bitCount=0 next cycle, offered bit dropped; the next 8 bits form a fresh word.
- Reset asserted in HOLD with outputValid=1 -> next cycle outputValid=0, outputData=0, inputReady=1, bitCount=0.
- INPUT_WIDTH=1, stream 1,0 with outputReady=1 -> results 1 then 0, each valid one cycle after its transfer, with one bubble between words.

Source files
------------

// File: rtl/_or_serial.sv
// Bit-serial OR reducer: ORs INPUT_WIDTH handshaked input bits into one result
// bit and offers that result on a valid/ready output.
//
// Optional build macro: OR_SERIAL_FIRST_INDEX_EN adds firstIndex/firstIndexValid,
// which report the arrival index of the first 1 bit in the word.
//
// state | meaning
// ACCUM | accepting bits, accumulating the OR of the current word
// HOLD  | word complete, result held on outputData until outputReady
//
// Constant levels (reset values, clears, saturation) are taken from DigitSupply.
module _or_serial #(
    parameter int INPUT_WIDTH = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [1:0]             DigitSupply,
    input  logic                   inputBit,
    input  logic                   inputValid,
    output logic                   inputReady,
    input  logic                   clearIn,
    output logic                   outputData,
    output logic                   outputValid,
    input  logic                   outputReady,
    output logic [COUNT_WIDTH-1:0] bitCount
`ifdef OR_SERIAL_FIRST_INDEX_EN
    ,
    output logic [COUNT_WIDTH-1:0] firstIndex,
    output logic                   firstIndexValid
`endif
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } stateT;

    localparam logic [COUNT_WIDTH-1:0] LastIndex = COUNT_WIDTH'(INPUT_WIDTH - 1);

    stateT                   state;
    stateT                   nextState;
    logic                    acc;
    logic                    nextAcc;
    logic                    inputXfer;
    logic                    outputXfer;
    logic                    lastBit;
    logic [COUNT_WIDTH-1:0]  zeroCount;

    assign zeroCount  = {COUNT_WIDTH{DigitSupply[0]}};
    assign inputXfer  = inputValid && inputReady;
    assign outputXfer = outputValid && outputReady;
    assign lastBit    = (bitCount == LastIndex);
    // A 1 bit saturates the accumulator at the supplied logic-1 level.
    assign nextAcc    = inputBit ? DigitSupply[1] : acc;

    // State register; reset returns to ACCUM.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ACCUM;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: clearIn aborts either state, otherwise complete word / accept result.
    always_comb begin
        nextState = state;
        unique case (state)
            ACCUM: begin
                if (!clearIn && inputXfer && lastBit) begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (clearIn || outputReady) begin
                    nextState = ACCUM;
                end
            end
            default: nextState = ACCUM;
        endcase
    end

    // Handshake outputs decoded from state; the HOLD state is the valid result.
    always_comb begin
        inputReady  = 1'b0;
        outputValid = 1'b0;
        unique case (state)
            ACCUM:   inputReady  = 1'b1;
            HOLD:    outputValid = 1'b1;
            default: inputReady  = 1'b0;
        endcase
    end

    // Datapath: accumulator, bit counter and result register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc        <= DigitSupply[0];
            bitCount   <= zeroCount;
            outputData <= DigitSupply[0];
        end else if (clearIn) begin
            acc      <= DigitSupply[0];
            bitCount <= zeroCount;
        end else if (inputXfer) begin
            acc      <= nextAcc;
            // The last bit lands bitCount exactly on INPUT_WIDTH, where it parks.
            bitCount <= bitCount + COUNT_WIDTH'(1);
            if (lastBit) begin
                outputData <= nextAcc;
            end
        end else if (outputXfer) begin
            acc      <= DigitSupply[0];
            bitCount <= zeroCount;
        end
    end

`ifdef OR_SERIAL_FIRST_INDEX_EN
    // First-one tracker: latches the arrival index of the first 1 bit of the word.
    always_ff @(posedge Clock) begin
        if (Reset || clearIn || (outputXfer && !inputXfer)) begin
            firstIndex      <= zeroCount;
            firstIndexValid <= DigitSupply[0];
        end else if (inputXfer && inputBit && !firstIndexValid) begin
            firstIndex      <= bitCount;
            firstIndexValid <= DigitSupply[1];
        end
    end
`endif

endmodule

// File: tb/tb__or_serial.sv
// Testbench for _or_serial: directed scenarios plus a randomized run checked
// against a word-level model (queue of accepted bits, pending-result flag).
module tb__or_serial;

    localparam int W = 8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] DigitSupply = 2'b10;

    logic       inputBit, inputValid, inputReady, clearIn;
    logic       outputData, outputValid, outputReady;
    logic [7:0] bitCount;

    logic       bBit, bValid, bReady, bClear;
    logic       bData, bOutValid, bOutReady;
    logic [7:0] bCount;

`ifdef OR_SERIAL_FIRST_INDEX_EN
    logic [7:0] firstIndex, bFirstIndex;
    logic       firstIndexValid, bFirstIndexValid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    _or_serial #(.INPUT_WIDTH(W), .COUNT_WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .DigitSupply(DigitSupply),
        .inputBit(inputBit), .inputValid(inputValid), .inputReady(inputReady),
        .clearIn(clearIn), .outputData(outputData), .outputValid(outputValid),
        .outputReady(outputReady), .bitCount(bitCount)
`ifdef OR_SERIAL_FIRST_INDEX_EN
        , .firstIndex(firstIndex), .firstIndexValid(firstIndexValid)
`endif
    );

    _or_serial #(.INPUT_WIDTH(1), .COUNT_WIDTH(8)) dutOne (
        .Clock(Clock), .Reset(Reset), .DigitSupply(DigitSupply),
        .inputBit(bBit), .inputValid(bValid), .inputReady(bReady),
        .clearIn(bClear), .outputData(bData), .outputValid(bOutValid),
        .outputReady(bOutReady), .bitCount(bCount)
`ifdef OR_SERIAL_FIRST_INDEX_EN
        , .firstIndex(bFirstIndex), .firstIndexValid(bFirstIndexValid)
`endif
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; inputValid = 1'b1; inputBit = 1'b1;
        tick(); tick();
        Reset = 1'b0; inputValid = 1'b0; inputBit = 1'b0;
        checks++;
        if ({inputReady, outputValid, outputData, bitCount} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b data=%b cnt=%0d, want rdy=1 vld=0 data=0 cnt=0",
                     inputReady, outputValid, outputData, bitCount);
        end
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < W; i++) begin
            inputBit = 1'b0; inputValid = 1'b1;
            tick();
            checks++;
            if (bitCount !== 8'(i + 1) || outputValid !== (i == W - 1)) begin
                errors++;
                $display("FAIL zero_word_bit%0d: cnt=%0d vld=%b, want cnt=%0d vld=%b",
                         i, bitCount, outputValid, i + 1, i == W - 1);
            end
        end
        inputValid = 1'b0;
        checks++;
        if (outputData !== 1'b0) begin
            errors++;
            $display("FAIL zero_word_data: data=%b, want 0", outputData);
        end
        outputReady = 1'b1;
        tick();
        outputReady = 1'b0;
        checks++;
        if ({outputValid, inputReady, bitCount} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL zero_word_accept: vld=%b rdy=%b cnt=%0d, want vld=0 rdy=1 cnt=0",
                     outputValid, inputReady, bitCount);
        end
    endtask

    task automatic test_hold_stall();
        logic [7:0] w;
        w = 8'b0000_0100;
        for (int i = 0; i < W; i++) begin
            inputBit = w[i]; inputValid = 1'b1;
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            inputValid = 1'b1; inputBit = 1'($urandom); outputReady = 1'b0;
            tick();
            checks++;
            if ({outputValid, outputData, inputReady, bitCount} !== {1'b1, 1'b1, 1'b0, 8'd8}) begin
                errors++;
                $display("FAIL hold_stall_c%0d: vld=%b data=%b rdy=%b cnt=%0d, want 1 1 0 8",
                         c, outputValid, outputData, inputReady, bitCount);
            end
`ifdef OR_SERIAL_FIRST_INDEX_EN
            checks++;
            if ({firstIndexValid, firstIndex} !== {1'b1, 8'd2}) begin
                errors++;
                $display("FAIL hold_first_index: fiv=%b fi=%0d, want fiv=1 fi=2",
                         firstIndexValid, firstIndex);
            end
`endif
        end
        inputValid = 1'b0; outputReady = 1'b1;
        tick();
        outputReady = 1'b0;
        checks++;
        if ({outputValid, bitCount} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL hold_accept: vld=%b cnt=%0d, want vld=0 cnt=0", outputValid, bitCount);
        end
`ifdef OR_SERIAL_FIRST_INDEX_EN
        checks++;
        if (firstIndexValid !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept_fiv: fiv=%b, want 0", firstIndexValid);
        end
`endif
    endtask

    task automatic test_gapped();
        bit q[$];
        bit e;
        e = 1'b0;
        for (int c = 0; c < 2 * W; c++) begin
            inputValid = (c % 2 == 0);
            inputBit   = 1'($urandom);
            if (inputValid) q.push_back(inputBit);
            tick();
            checks++;
            if (bitCount !== 8'(q.size()) || outputValid !== (q.size() == W)) begin
                errors++;
                $display("FAIL gapped_c%0d: cnt=%0d vld=%b, want cnt=%0d vld=%b",
                         c, bitCount, outputValid, q.size(), q.size() == W);
            end
        end
        inputValid = 1'b0;
        foreach (q[k]) e |= q[k];
        checks++;
        if (outputData !== e) begin
            errors++;
            $display("FAIL gapped_data: data=%b, want %b", outputData, e);
        end
        outputReady = 1'b1;
        tick();
        outputReady = 1'b0;
    endtask

    task automatic test_clear();
        logic [3:0] head;
        head = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            inputBit = head[i]; inputValid = 1'b1;
            tick();
        end
        checks++;
        if (bitCount !== 8'd4) begin
            errors++;
            $display("FAIL clear_pre: cnt=%0d, want 4", bitCount);
        end
        clearIn = 1'b1; inputValid = 1'b1; inputBit = 1'b1;
        tick();
        clearIn = 1'b0;
        checks++;
        if ({outputValid, bitCount} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clear_accum: vld=%b cnt=%0d, want vld=0 cnt=0", outputValid, bitCount);
        end
`ifdef OR_SERIAL_FIRST_INDEX_EN
        checks++;
        if (firstIndexValid !== 1'b0) begin
            errors++;
            $display("FAIL clear_fiv: fiv=%b, want 0", firstIndexValid);
        end
`endif
        for (int i = 0; i < W; i++) begin
            inputBit = 1'b0; inputValid = 1'b1;
            tick();
            if (i == W - 2) begin
                checks++;
                if (outputValid !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_fresh_early: vld=%b after 7 bits, want 0", outputValid);
                end
            end
        end
        inputValid = 1'b0;
        checks++;
        if ({outputValid, outputData, bitCount} !== {1'b1, 1'b0, 8'd8}) begin
            errors++;
            $display("FAIL clear_fresh_word: vld=%b data=%b cnt=%0d, want 1 0 8",
                     outputValid, outputData, bitCount);
        end
        clearIn = 1'b1;
        tick();
        clearIn = 1'b0;
        checks++;
        if ({outputValid, inputReady, bitCount} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL clear_hold: vld=%b rdy=%b cnt=%0d, want 0 1 0",
                     outputValid, inputReady, bitCount);
        end
    endtask

    task automatic test_reset_in_hold();
        for (int i = 0; i < W; i++) begin
            inputBit = 1'b1; inputValid = 1'b1;
            tick();
        end
        inputValid = 1'b0;
        checks++;
        if ({outputValid, outputData} !== 2'b11) begin
            errors++;
            $display("FAIL reset_hold_pre: vld=%b data=%b, want 1 1", outputValid, outputData);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({outputValid, outputData, inputReady, bitCount} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_hold: vld=%b data=%b rdy=%b cnt=%0d, want 0 0 1 0",
                     outputValid, outputData, inputReady, bitCount);
        end
    endtask

    task automatic test_random();
        bit q[$];
        bit pending;
        bit expData;
        int expFirst;
        pending = 1'b0; expData = 1'b0; expFirst = -1;
        for (int c = 0; c < 400; c++) begin
            inputValid  = ($urandom_range(0, 3) != 0);
            inputBit    = ($urandom_range(0, 4) == 0);
            outputReady = ($urandom_range(0, 2) == 0);
            if (!pending && inputValid) begin
                q.push_back(inputBit);
                if (q.size() == W) begin
                    pending  = 1'b1;
                    expData  = 1'b0;
                    expFirst = -1;
                    foreach (q[k]) begin
                        expData |= q[k];
                        if (q[k] && expFirst < 0) expFirst = k;
                    end
                end
            end else if (pending && outputReady) begin
                pending = 1'b0;
                q.delete();
            end
            tick();
            checks++;
            if ({outputValid, inputReady, bitCount} !== {pending, !pending, 8'(q.size())} ||
                (pending && outputData !== expData)) begin
                errors++;
                $display("FAIL random_c%0d: vld=%b rdy=%b cnt=%0d data=%b, want vld=%b rdy=%b cnt=%0d data=%b",
                         c, outputValid, inputReady, bitCount, outputData,
                         pending, !pending, q.size(), expData);
            end
`ifdef OR_SERIAL_FIRST_INDEX_EN
            if (pending) begin
                checks++;
                if (firstIndexValid !== (expFirst >= 0) ||
                    (expFirst >= 0 && firstIndex !== 8'(expFirst))) begin
                    errors++;
                    $display("FAIL random_first_c%0d: fiv=%b fi=%0d, want fiv=%b fi=%0d",
                             c, firstIndexValid, firstIndex, expFirst >= 0, expFirst);
                end
            end
`endif
        end
        inputValid = 1'b0; outputReady = 1'b1;
        tick();
        outputReady = 1'b0;
    endtask

    task automatic test_width1();
        bValid = 1'b1; bBit = 1'b1; bOutReady = 1'b1;
        tick();
        checks++;
        if ({bOutValid, bData, bReady, bCount} !== {1'b1, 1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL w1_first: vld=%b data=%b rdy=%b cnt=%0d, want 1 1 0 1",
                     bOutValid, bData, bReady, bCount);
        end
        bBit = 1'b0;
        tick();
        checks++;
        if ({bOutValid, bReady, bCount} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL w1_bubble: vld=%b rdy=%b cnt=%0d, want 0 1 0", bOutValid, bReady, bCount);
        end
        tick();
        checks++;
        if ({bOutValid, bData, bReady, bCount} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL w1_second: vld=%b data=%b rdy=%b cnt=%0d, want 1 0 0 1",
                     bOutValid, bData, bReady, bCount);
        end
        bValid = 1'b0;
        tick();
        bOutReady = 1'b0;
        checks++;
        if ({bOutValid, bReady, bCount} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL w1_done: vld=%b rdy=%b cnt=%0d, want 0 1 0", bOutValid, bReady, bCount);
        end
    endtask

    initial begin
        Reset = 1'b1; inputBit = 1'b0; inputValid = 1'b0; clearIn = 1'b0; outputReady = 1'b0;
        bBit = 1'b0; bValid = 1'b0; bClear = 1'b0; bOutReady = 1'b0;
        test_reset();
        test_all_zero();
        test_hold_stall();
        test_gapped();
        test_clear();
        test_reset_in_hold();
        test_random();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
